// File: rtl/uart_tx_fifo_if.sv
// Byte write port into the UART transmit FIFO: valid/ready handshake with 8-bit data.
interface uart_tx_fifo_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small circular FIFO; frames go out back-to-back,
// LSB first, each bit held for CLK_DIV clocks.
module uart_tx_fifo #(
    parameter int unsigned CLK_DIV = 16,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    uart_tx_fifo_if.slave                tx,
    output logic                         ser_tx,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = $clog2(DEPTH + 1);
    localparam int unsigned CntW = $clog2(CLK_DIV);
    localparam logic [CntW-1:0] CntReload = CntW'(CLK_DIV - 1);
    localparam logic [LvlW-1:0] LvlFull   = LvlW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic [7:0]      mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0] level_q;
    logic [7:0]      shift_q, shift_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic            ser_q, ser_d;
    logic            push, pop, fifo_empty, baud_done;

    assign fifo_empty  = (level_q == '0);
    assign tx.tx_ready = (level_q != LvlFull);
    assign push        = tx.tx_valid && tx.tx_ready;
    assign baud_done   = (cnt_q == '0);

    assign ser_tx     = ser_q;
    assign busy       = (state_q != StIdle) || !fifo_empty;
    assign fifo_level = level_q;

    // FIFO bookkeeping; the level is tracked separately so full and empty are unambiguous.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop) begin
                level_q <= level_q + 1'b1;
            end else if (pop && !push) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= tx.tx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            ser_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            ser_q   <= ser_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (!fifo_empty) state_d = StStart;
            StStart: if (baud_done) state_d = StData;
            StData:  if (baud_done && bit_q == 3'd7) state_d = StStop;
            StStop:  if (baud_done) state_d = fifo_empty ? StIdle : StStart;
            default: state_d = StIdle;
        endcase
    end

    // Datapath: the pop and the start-bit drive always happen on the same edge.
    always_comb begin
        pop     = 1'b0;
        ser_d   = ser_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q - 1'b1;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    ser_d   = 1'b0;
                    cnt_d   = CntReload;
                end
            end
            StStart: begin
                if (baud_done) begin
                    ser_d = shift_q[0];
                    cnt_d = CntReload;
                    bit_d = '0;
                end
            end
            StData: begin
                if (baud_done) begin
                    cnt_d = CntReload;
                    if (bit_q == 3'd7) begin
                        ser_d = 1'b1;
                    end else begin
                        shift_d = shift_q >> 1;
                        ser_d   = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
            StStop: begin
                if (baud_done && !fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    ser_d   = 1'b0;
                    cnt_d   = CntReload;
                end
            end
            default: ;
        endcase
    end
endmodule
